// File: rtl/merge_pkg.sv
// Shared types and constants for the two-way streaming merge stage.
package merge_pkg;

    typedef enum logic [1:0] {
        MERGE   = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2
    } merge_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int unsigned DEFAULT_WIDTH     = 32;
    localparam int unsigned DEFAULT_KEY_WIDTH = 32;

endpackage

// File: rtl/key_compare.sv
// Unsigned key comparator built from two half-width subtractions.
// Equality output is only generated when MERGE_DUP_DETECT_EN is defined.
module key_compare #(
    parameter int unsigned KEY_WIDTH = 32
) (
    input  logic [KEY_WIDTH-1:0] key_a,
    input  logic [KEY_WIDTH-1:0] key_b,
    output logic                 a_le_b,
    output logic                 eq
);

    if (KEY_WIDTH == 1) begin : g_narrow
        assign a_le_b = !key_a[0] || key_b[0];
`ifdef MERGE_DUP_DETECT_EN
        assign eq = (key_a[0] == key_b[0]);
`else
        assign eq = 1'b0;
`endif
    end else begin : g_split
        localparam int unsigned LO_W = KEY_WIDTH / 2;
        localparam int unsigned HI_W = KEY_WIDTH - LO_W;

        logic [LO_W:0] lo_diff;
        logic [HI_W:0] hi_diff;
        logic          lo_lt, lo_eq, hi_lt, hi_eq;

        // The extra top bit of each difference is the borrow, i.e. "a < b" for that half.
        always_comb begin
            lo_diff = {1'b0, key_a[LO_W-1:0]} - {1'b0, key_b[LO_W-1:0]};
            hi_diff = {1'b0, key_a[KEY_WIDTH-1:LO_W]} - {1'b0, key_b[KEY_WIDTH-1:LO_W]};
            lo_lt   = lo_diff[LO_W];
            lo_eq   = (lo_diff[LO_W-1:0] == '0);
            hi_lt   = hi_diff[HI_W];
            hi_eq   = (hi_diff[HI_W-1:0] == '0);
        end

        assign a_le_b = hi_lt || (hi_eq && (lo_lt || lo_eq));
`ifdef MERGE_DUP_DETECT_EN
        assign eq = hi_eq && lo_eq;
`else
        assign eq = 1'b0;
`endif
    end

endmodule

// File: rtl/merge_stream.sv
// Two-way streaming merge of sorted runs with a registered output stage.
// Define MERGE_DUP_DETECT_EN to enable the sticky equal-key dup_flag.
module merge_stream
    import merge_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned KEY_WIDTH = DEFAULT_KEY_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,

    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,

    output logic             dup_flag
);

    merge_state_e state_q;

    logic adv;
    logic both_valid;
    logic a_le_b;
    logic a_fire;
    logic b_fire;

`ifdef MERGE_DUP_DETECT_EN
    logic key_eq;
    logic dup_q;
`else
    logic unused_key_eq;
`endif

    key_compare #(
        .KEY_WIDTH (KEY_WIDTH)
    ) u_key_compare (
        .key_a  (a_data[WIDTH-1 -: KEY_WIDTH]),
        .key_b  (b_data[WIDTH-1 -: KEY_WIDTH]),
        .a_le_b (a_le_b),
`ifdef MERGE_DUP_DETECT_EN
        .eq     (key_eq)
`else
        .eq     (unused_key_eq)
`endif
    );

    assign adv        = !out_valid || out_ready;
    assign both_valid = a_valid && b_valid;

    // Readies are forced low during reset so upstream never sees a phantom pop.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                MERGE: begin
                    a_ready = adv && both_valid && a_le_b;
                    b_ready = adv && both_valid && !a_le_b;
                end
                DRAIN_A: a_ready = adv;
                DRAIN_B: b_ready = adv;
                default: ;
            endcase
        end
    end

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MERGE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= SRC_A;
`ifdef MERGE_DUP_DETECT_EN
            dup_q     <= 1'b0;
`endif
        end else begin
            if (adv) begin
                out_valid <= a_fire || b_fire;
                if (a_fire) begin
                    out_data <= a_data;
                    out_src  <= SRC_A;
                    out_last <= (state_q == DRAIN_A) && a_last;
                end else if (b_fire) begin
                    out_data <= b_data;
                    out_src  <= SRC_B;
                    out_last <= (state_q == DRAIN_B) && b_last;
                end
            end

            unique case (state_q)
                MERGE: begin
                    if (a_fire && a_last) begin
                        state_q <= DRAIN_B;
                    end else if (b_fire && b_last) begin
                        state_q <= DRAIN_A;
                    end
                end
                DRAIN_A: if (a_fire && a_last) state_q <= MERGE;
                DRAIN_B: if (b_fire && b_last) state_q <= MERGE;
                default: state_q <= MERGE;
            endcase

`ifdef MERGE_DUP_DETECT_EN
            // A new equal-key decision wins over the end-of-run clear.
            if ((state_q == MERGE) && (a_fire || b_fire) && key_eq) begin
                dup_q <= 1'b1;
            end else if (out_valid && out_ready && out_last) begin
                dup_q <= 1'b0;
            end
`endif
        end
    end

`ifdef MERGE_DUP_DETECT_EN
    assign dup_flag = dup_q;
`else
    assign dup_flag = 1'b0;
`endif

endmodule

// File: tb/tb_merge_stream.sv
// Directed self-checking bench for merge_stream; honours MERGE_DUP_DETECT_EN.
module tb_merge_stream;

`ifdef MERGE_DUP_DETECT_EN
    localparam logic DUP_EN = 1'b1;
`else
    localparam logic DUP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready;
    logic        out_valid, out_last, out_src, dup_flag;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] qa_d[$], qb_d[$];
    logic        qa_l[$], qb_l[$];
    logic [33:0] got[$];
    logic        got_dup[$];

    int stall_at = 0, stall_len = 0, hold_at = 0, hold_len = 0;
    int run_cycles;
    logic timed_out;
    logic snap_valid, snap_src, snap_last;
    logic [31:0] snap_data;
    logic stall_changed, stall_ready_seen, hold_pop_seen, hold_end_valid;

    always #5 clk = ~clk;

    merge_stream #(
        .WIDTH     (32),
        .KEY_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .a_last    (a_last),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_last    (b_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .dup_flag  (dup_flag)
    );

    // Output transfers recorded as {data, src, last}.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got.push_back({out_data, out_src, out_last});
            got_dup.push_back(dup_flag);
        end
    end

    task automatic push_a(input logic [31:0] d, input logic l);
        qa_d.push_back(d);
        qa_l.push_back(l);
    endtask

    task automatic push_b(input logic [31:0] d, input logic l);
        qb_d.push_back(d);
        qb_l.push_back(l);
    endtask

    // Plays the queued runs as eager sources; optional out_ready stall and b_valid hold windows.
    task automatic run_pair();
        int ia = 0, ib = 0, cyc = 0;
        int na = qa_d.size();
        int nb = qb_d.size();
        logic fa, fb, in_stall, in_hold;
        got.delete();
        got_dup.delete();
        timed_out = 1'b0;
        snap_valid = 1'b0; snap_data = '0; snap_src = 1'b0; snap_last = 1'b0;
        stall_changed = 1'b0; stall_ready_seen = 1'b0;
        hold_pop_seen = 1'b0; hold_end_valid = 1'b0;
        while (ia < na || ib < nb) begin
            if (cyc >= 100) begin
                timed_out = 1'b1;
                break;
            end
            in_stall  = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            in_hold   = (cyc >= hold_at) && (cyc < hold_at + hold_len);
            out_ready = !in_stall;
            a_valid   = (ia < na);
            a_data    = (ia < na) ? qa_d[ia] : '0;
            a_last    = (ia < na) ? qa_l[ia] : 1'b0;
            b_valid   = (ib < nb) && !in_hold;
            b_data    = (ib < nb) ? qb_d[ib] : '0;
            b_last    = (ib < nb) ? qb_l[ib] : 1'b0;
            @(negedge clk);
            fa = a_valid && a_ready;
            fb = b_valid && b_ready;
            if (in_stall) begin
                if (cyc == stall_at) begin
                    snap_valid = out_valid; snap_data = out_data;
                    snap_src = out_src; snap_last = out_last;
                end else if (out_valid !== snap_valid || out_data !== snap_data ||
                             out_src !== snap_src || out_last !== snap_last) begin
                    stall_changed = 1'b1;
                end
                if (a_ready || b_ready) stall_ready_seen = 1'b1;
            end
            if (in_hold) begin
                if (fa || fb) hold_pop_seen = 1'b1;
                if (cyc == hold_at + hold_len - 1) hold_end_valid = out_valid;
            end
            @(posedge clk);
            #1;
            if (fa) ia++;
            if (fb) ib++;
            cyc++;
        end
        run_cycles = cyc;
        a_valid = 1'b0;
        b_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        qa_d.delete(); qa_l.delete(); qb_d.delete(); qb_l.delete();
        stall_len = 0;
        hold_len = 0;
    endtask

    task automatic test_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        tests++;
        if ({out_valid, out_data, out_last, out_src, dup_flag} !== 36'd0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b d=%h l=%b s=%b dup=%b want all 0",
                     out_valid, out_data, out_last, out_src, dup_flag);
        end
        tests++;
        if ({a_ready, b_ready} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready got %b%b want 00", a_ready, b_ready);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [33:0] exp [6] = '{{32'd1, 2'b00}, {32'd2, 2'b10}, {32'd3, 2'b10},
                                 {32'd4, 2'b00}, {32'd9, 2'b00}, {32'd10, 2'b11}};
        push_a(1, 0); push_a(4, 0); push_a(9, 1);
        push_b(2, 0); push_b(3, 0); push_b(10, 1);
        run_pair();
        tests++;
        if (timed_out || got.size() != 6) begin
            fails++;
            $display("FAIL basic_count got %0d (timeout %b) want 6", got.size(), timed_out);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                fails++;
                $display("FAIL basic_elem%0d got %h want %h", i, got[i], exp[i]);
            end
        end
        tests++;
        if (run_cycles != 6) begin
            fails++;
            $display("FAIL basic_throughput got %0d cycles want 6", run_cycles);
        end
        tests++;
        if (dup_flag !== 1'b0 || got_dup.size() != 6 || got_dup[5] !== 1'b0) begin
            fails++;
            $display("FAIL basic_dup got %b want 0", dup_flag);
        end
    endtask

    task automatic test_equal_keys();
        logic [33:0] exp [2] = '{{32'd5, 2'b00}, {32'd5, 2'b11}};
        push_a(5, 1);
        push_b(5, 1);
        run_pair();
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                fails++;
                $display("FAIL equal_elem%0d got %h want %h", i, got[i], exp[i]);
            end
            tests++;
            if (i >= got_dup.size() || got_dup[i] !== DUP_EN) begin
                fails++;
                $display("FAIL equal_dup%0d got %b want %b", i, got_dup[i], DUP_EN);
            end
        end
        tests++;
        if (dup_flag !== 1'b0) begin
            fails++;
            $display("FAIL equal_dup_clear got %b want 0", dup_flag);
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] exp [6] = '{{32'd1, 2'b00}, {32'd2, 2'b10}, {32'd3, 2'b10},
                                 {32'd4, 2'b00}, {32'd9, 2'b00}, {32'd10, 2'b11}};
        push_a(1, 0); push_a(4, 0); push_a(9, 1);
        push_b(2, 0); push_b(3, 0); push_b(10, 1);
        stall_at = 2;
        stall_len = 3;
        run_pair();
        tests++;
        if ({snap_valid, snap_data, snap_src, snap_last} !== {1'b1, 32'd2, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL bp_held_output got v=%b d=%0d s=%b l=%b want v=1 d=2 s=1 l=0",
                     snap_valid, snap_data, snap_src, snap_last);
        end
        tests++;
        if (stall_changed !== 1'b0) begin
            fails++;
            $display("FAIL bp_stable got changed=%b want 0", stall_changed);
        end
        tests++;
        if (stall_ready_seen !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready got ready_seen=%b want 0", stall_ready_seen);
        end
        tests++;
        if (got.size() != 6 || run_cycles != 9) begin
            fails++;
            $display("FAIL bp_count got %0d elems %0d cycles want 6 elems 9 cycles",
                     got.size(), run_cycles);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                fails++;
                $display("FAIL bp_elem%0d got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_one_side_stall();
        logic [33:0] exp [6] = '{{32'd1, 2'b00}, {32'd2, 2'b10}, {32'd3, 2'b10},
                                 {32'd4, 2'b00}, {32'd9, 2'b00}, {32'd10, 2'b11}};
        push_a(1, 0); push_a(4, 0); push_a(9, 1);
        push_b(2, 0); push_b(3, 0); push_b(10, 1);
        hold_at = 2;
        hold_len = 3;
        run_pair();
        tests++;
        if (hold_pop_seen !== 1'b0) begin
            fails++;
            $display("FAIL stall_no_pop got pop_seen=%b want 0", hold_pop_seen);
        end
        tests++;
        if (hold_end_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_out_valid got %b want 0", hold_end_valid);
        end
        tests++;
        if (got.size() != 6 || run_cycles != 9) begin
            fails++;
            $display("FAIL stall_count got %0d elems %0d cycles want 6 elems 9 cycles",
                     got.size(), run_cycles);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                fails++;
                $display("FAIL stall_elem%0d got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_uneven();
        logic [33:0] exp [5] = '{{32'd1, 2'b10}, {32'd2, 2'b10}, {32'd3, 2'b10},
                                 {32'd7, 2'b00}, {32'd8, 2'b11}};
        push_a(7, 1);
        push_b(1, 0); push_b(2, 0); push_b(3, 0); push_b(8, 1);
        run_pair();
        tests++;
        if (got.size() != 5 || run_cycles != 5) begin
            fails++;
            $display("FAIL uneven_count got %0d elems %0d cycles want 5 elems 5 cycles",
                     got.size(), run_cycles);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                fails++;
                $display("FAIL uneven_elem%0d got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp [4] = '{{32'd5, 2'b00}, {32'd6, 2'b11}, {32'd1, 2'b10},
                                 {32'd2, 2'b01}};
        push_a(5, 1); push_a(2, 1);
        push_b(6, 1); push_b(1, 1);
        run_pair();
        tests++;
        if (got.size() != 4 || run_cycles != 4) begin
            fails++;
            $display("FAIL b2b_count got %0d elems %0d cycles want 4 elems 4 cycles",
                     got.size(), run_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                fails++;
                $display("FAIL b2b_elem%0d got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [33:0] exp [3] = '{{32'd3, 2'b00}, {32'd4, 2'b10}, {32'd6, 2'b01}};
        a_valid = 1'b1; a_data = 32'd5; a_last = 1'b1;
        b_valid = 1'b1; b_data = 32'd9; b_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd5) begin
            fails++;
            $display("FAIL midreset_pre got v=%b d=%0d want v=1 d=5", out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_data, out_last, out_src, a_ready, b_ready} !== 38'd0) begin
            fails++;
            $display("FAIL midreset_clear got v=%b d=%h l=%b s=%b ar=%b br=%b want all 0",
                     out_valid, out_data, out_last, out_src, a_ready, b_ready);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_a(3, 0); push_a(6, 1);
        push_b(4, 1);
        run_pair();
        tests++;
        if (got.size() != 3) begin
            fails++;
            $display("FAIL midreset_count got %0d want 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                fails++;
                $display("FAIL midreset_elem%0d got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_equal_keys();
        test_backpressure();
        test_one_side_stall();
        test_uneven();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/merge_stream.md
# merge_stream

Two-way streaming merge stage for the field-ordering mergesort. It accepts two independently sorted runs over valid/ready handshakes and compares their head elements on a key field. It pops the smaller head into a registered output stream, producing one merged sorted run per pair of input runs. Cascaded instances form the merge tree; the key comparator supplies the ordering decision, and this block is its consumer and sequencer.

## Interface
- WIDTH, 32, total element width in bits
- KEY_WIDTH, 32, compared key width; the key is element bits [WIDTH-1 -: KEY_WIDTH], and 1 ≤ KEY_WIDTH ≤ WIDTH
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_valid / a_ready  in / out  1  run-A handshake
- a_data  in  WIDTH  run-A head element
- a_last  in  1  marks the final element of the current A run
- b_valid / b_ready / b_data / b_last: same as A, for run B
- out_valid / out_ready  out / in  1  merged-stream handshake
- out_data  out  WIDTH  merged element
- out_last  out  1  final element of the merged run
- out_src  out  1  source of out_data: 0 = A, 1 = B
- dup_flag  out  1  sticky equal-key indicator for the current run (see Configuration)

## Operation
- adv = !out_valid || out_ready. When adv is 1, the output register may load.
- At most one input is popped per cycle. An input transfer occurs when x_valid && x_ready.
- States:
  - MERGE: both runs are active.
    - Waits until a_valid && b_valid. A decision is never made on one valid head.
    - Compares keys. If keyA ≤ keyB, pops A; otherwise pops B. Ties go to A (stable).
    - a_ready = adv && a_valid && b_valid && (keyA ≤ keyB). b_ready is the complement condition.
    - Popping an element with last=1 moves to DRAIN_B (if A finished) or DRAIN_A (if B finished). out_last = 0.
  - DRAIN_A: B is finished.
    - a_ready = adv. b_ready = 0. A elements pass through.
    - Popping A with a_last=1 sets out_last=1 and moves to MERGE.
  - DRAIN_B: mirror of DRAIN_A.
- out_src is 0 for A and 1 for B. out_data is the popped element unmodified.
- When adv is 0, out_* hold stable and both ready signals are 0.
- A single-element run (last on its first element) is legal. It goes straight to DRAIN of the other input.
- Keys are compared unsigned, over KEY_WIDTH bits only. Non-key bits never affect ordering.

## Timing
- Reset values:
  - out_valid, out_data, out_last, out_src and dup_flag are all 0.
  - State is MERGE.
  - a_ready and b_ready are 0 while rst_n is low.
- Latency: an input transfer in cycle N gives out_valid=1 with that element in cycle N+1.
- Throughput: one element per cycle when out_ready is held at 1 and the required inputs are valid.
- Ready signals are combinational from valid, key compare, state and out_ready. No valid depends on a ready.
- Reset asserted mid-run:
  - Output is dropped immediately and state returns to MERGE.
  - Partially consumed runs are discarded. Upstream must also be reset.
- Back-to-back runs: the first element of the next run may be popped in the same cycle out_last is presented, if adv is 1.

## Configuration
- MERGE_DUP_DETECT_EN defined:
  - dup_flag sets when a MERGE decision is taken with keyA == keyB.
  - It stays set through the run. It clears on the cycle after the out_last transfer (out_valid && out_ready && out_last), unless a new equal-key decision occurs in that same cycle.
  - Upstream uses this to reject non-unique field-ordering keys.
- Not defined: dup_flag is constant 0, and no equality logic is synthesized.

## Structure
- Package merge_pkg holds:
  - the state encoding: MERGE=2'd0, DRAIN_A=2'd1, DRAIN_B=2'd2
  - the SRC_A/SRC_B constants
  - the default WIDTH/KEY_WIDTH localparams
- One sub-module, key_compare:
  - Combinational. Inputs are two KEY_WIDTH keys; outputs are a_le_b and eq.
  - Uses the split-half subtraction scheme for timing.
  - Instantiated once.

## Test plan
- Runs A = {1,4,9 last} and B = {2,3,10 last}, with out_ready held at 1 → out_data 1,2,3,4,9,10. out_src 0,1,1,0,0,1. out_last only on 10.
- Equal keys: A = {5 last}, B = {5 last}, with MERGE_DUP_DETECT_EN → A's 5 first (src 0), then B's 5 with out_last. dup_flag=1 until the cycle after the last transfer.
- Backpressure: hold out_ready=0 for 3 cycles mid-run → out_data, out_last and out_src stable; a_ready=b_ready=0; no element lost or duplicated.
- Stall on one side: a_valid=1, b_valid=0 in MERGE → no pop, out_valid falls after the current output drains. Raising b_valid resumes correct ordering.
- Uneven runs: A = {7 last}, B = {1,2,3,8 last} → 1,2,3,7,8. DRAIN_B is entered after 7; out_last on 8.
- Reset: assert rst_n=0 while out_valid=1 mid-run → all outputs 0 asynchronously. After release, a fresh run pair merges correctly.
